// File: rtl/dmp_domain_ctrl.sv
// dmp_domain_ctrl: owns the current DMP protection domain. A domain switch is
// accepted through a req/gnt handshake. New memory issue is stalled and in-flight
// accesses are drained before the new domain is committed, so every access is
// checked against the domain it was issued under.
module dmp_domain_ctrl #(
   parameter int MAX_OUTSTANDING = 8,
   parameter int DRAIN_TIMEOUT   = 64,
   parameter int DOM_W           = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             switch_req_i,
   input  logic [DOM_W-1:0] switch_dom_i,
   input  logic [1:0]       priv_lvl_i,
   output logic             switch_gnt_o,
   output logic             switch_done_o,
   output logic             switch_err_o,
   input  logic             mem_issue_i,
   input  logic             mem_retire_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic [DOM_W-1:0] curdom_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

   localparam logic [DOM_W-1:0] DOM0       = '0;
   localparam logic [1:0]       PRIV_LVL_U = 2'b00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   state_e           state_q;
   logic [DOM_W-1:0] curdom_q;
   logic [DOM_W-1:0] target_q;
   logic [TMR_W-1:0] timer_q;
   logic             stall_q;
   logic             done_q;
   logic             err_q;
   logic [CNT_W-1:0] outstanding_q;
   logic [CNT_W-1:0] outstanding_d;

   // Outstanding-access next state: saturating up/down count, issue+retire cancel.
   always_comb begin
      outstanding_d = outstanding_q;
      if (mem_issue_i && !mem_retire_i) begin
         if (outstanding_q != CNT_W'(MAX_OUTSTANDING)) begin
            outstanding_d = outstanding_q + 1'b1;
         end
      end else if (mem_retire_i && !mem_issue_i) begin
         if (outstanding_q != '0) begin
            outstanding_d = outstanding_q - 1'b1;
         end
      end
   end

   // Outstanding counter runs in every state; accesses past the stall point still count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

   // Switch FSM with registered done/err pulses, stall and current domain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         curdom_q <= DOM0;
         target_q <= DOM0;
         timer_q  <= '0;
         stall_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (switch_req_i) begin
                  if (priv_lvl_i == PRIV_LVL_U) begin
                     err_q <= 1'b1;
                  end else if (switch_dom_i == curdom_q) begin
                     done_q <= 1'b1;
                  end else begin
                     target_q <= switch_dom_i;
                     timer_q  <= '0;
                     stall_q  <= 1'b1;
                     state_q  <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               timer_q <= timer_q + 1'b1;
               if (flush_i) begin
                  err_q   <= 1'b1;
                  stall_q <= 1'b0;
                  state_q <= IDLE;
               end else if (outstanding_q == '0) begin
                  state_q <= COMMIT;
               end else if (timer_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  stall_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            COMMIT: begin
               // Commit always completes; flush is deliberately not looked at here.
               curdom_q <= target_q;
               done_q   <= 1'b1;
               stall_q  <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               stall_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign switch_gnt_o  = (state_q == IDLE);
   assign switch_done_o = done_q;
   assign switch_err_o  = err_q;
   assign stall_o       = stall_q;
   assign curdom_o      = curdom_q;

endmodule

// File: tb/tb_dmp_domain_ctrl.sv
// Testbench for dmp_domain_ctrl: each switch request pushes its expected outcome
// (done/err, domain, cycle) to a scoreboard that a pulse monitor pops and checks.
module tb_dmp_domain_ctrl;

   localparam int DOM_W = 2;
   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_M = 2'b11;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             switch_req_i;
   logic [DOM_W-1:0] switch_dom_i;
   logic [1:0]       priv_lvl_i;
   logic             switch_gnt_o;
   logic             switch_done_o;
   logic             switch_err_o;
   logic             mem_issue_i;
   logic             mem_retire_i;
   logic             flush_i;
   logic             stall_o;
   logic [DOM_W-1:0] curdom_o;

   typedef struct {
      bit               is_err;
      logic [DOM_W-1:0] dom;
      int               cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   dmp_domain_ctrl #(
      .MAX_OUTSTANDING (8),
      .DRAIN_TIMEOUT   (64),
      .DOM_W           (DOM_W)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .switch_req_i  (switch_req_i),
      .switch_dom_i  (switch_dom_i),
      .priv_lvl_i    (priv_lvl_i),
      .switch_gnt_o  (switch_gnt_o),
      .switch_done_o (switch_done_o),
      .switch_err_o  (switch_err_o),
      .mem_issue_i   (mem_issue_i),
      .mem_retire_i  (mem_retire_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .curdom_o      (curdom_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_exp(input bit is_err, input logic [DOM_W-1:0] dom, input int at);
      exp_t e;
      e.is_err = is_err;
      e.dom    = dom;
      e.cyc    = at;
      sb_q.push_back(e);
   endtask

   // Pulse monitor: every done/err pulse must match the oldest scoreboard entry.
   always @(negedge clk_i) begin
      if (rst_ni === 1'b1 && (switch_done_o || switch_err_o)) begin
         if (switch_done_o && switch_err_o) begin
            chk_eq("done_err_exclusive", 32'd1, 32'd0);
         end
         if (sb_q.size() == 0) begin
            chk_eq("unexpected_pulse", {30'd0, switch_done_o, switch_err_o}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk_eq("pulse_kind_err", {31'd0, switch_err_o}, {31'd0, e.is_err});
            chk_eq("pulse_curdom", {30'd0, curdom_o}, {30'd0, e.dom});
            chk_eq("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, pending=%0d expected 0", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst_ni       = 1'b0;
      switch_req_i = 1'b0;
      switch_dom_i = '0;
      priv_lvl_i   = PRIV_M;
      mem_issue_i  = 1'b0;
      mem_retire_i = 1'b0;
      flush_i      = 1'b0;
      tick();
      tick();
      chk_eq("rst_curdom", curdom_o, 0);
      chk_eq("rst_stall", stall_o, 0);
      chk_eq("rst_gnt", switch_gnt_o, 1);
      chk_eq("rst_done", switch_done_o, 0);
      chk_eq("rst_err", switch_err_o, 0);
      rst_ni = 1'b1;
      tick();

      // Clean switch DOM0 -> DOM1 with empty pipeline.
      c0 = cyc;
      switch_req_i = 1'b1;
      switch_dom_i = 2'd1;
      push_exp(1'b0, 2'd1, c0 + 3);
      tick();
      switch_req_i = 1'b0;
      chk_eq("clean_stall_c1", stall_o, 1);
      chk_eq("clean_gnt_c1", switch_gnt_o, 0);
      chk_eq("clean_curdom_c1", curdom_o, 0);
      tick();
      chk_eq("clean_stall_c2", stall_o, 1);
      tick();
      chk_eq("clean_stall_c3", stall_o, 0);
      chk_eq("clean_curdom_c3", curdom_o, 1);
      chk_eq("clean_gnt_c3", switch_gnt_o, 1);
      tick();
      chk_eq("clean_done_once", switch_done_o, 0);

      // Drain wait: 3 outstanding, retires start 5 cycles after the request.
      mem_issue_i = 1'b1;
      tick(); tick(); tick();
      mem_issue_i = 1'b0;
      c0 = cyc;
      switch_req_i = 1'b1;
      switch_dom_i = 2'd2;
      push_exp(1'b0, 2'd2, c0 + 11);
      tick();
      switch_req_i = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         mem_issue_i  = (k == 6);
         mem_retire_i = (k >= 5 && k <= 8);
         chk_eq($sformatf("drain_stall_k%0d", k), stall_o, (k <= 10) ? 1 : 0);
         tick();
      end
      mem_issue_i  = 1'b0;
      mem_retire_i = 1'b0;
      chk_eq("drain_curdom", curdom_o, 2);

      // No-op (target == current), then a user-mode refusal granted in the done cycle.
      c0 = cyc;
      switch_req_i = 1'b1;
      switch_dom_i = 2'd2;
      priv_lvl_i   = PRIV_M;
      push_exp(1'b0, 2'd2, c0 + 1);
      tick();
      chk_eq("noop_stall", stall_o, 0);
      chk_eq("noop_gnt", switch_gnt_o, 1);
      switch_dom_i = 2'd1;
      priv_lvl_i   = PRIV_U;
      push_exp(1'b1, 2'd2, c0 + 2);
      tick();
      switch_req_i = 1'b0;
      priv_lvl_i   = PRIV_M;
      chk_eq("refuse_stall", stall_o, 0);
      chk_eq("refuse_curdom", curdom_o, 2);
      tick();

      // Timeout: one access never retires.
      mem_issue_i = 1'b1;
      tick();
      mem_issue_i = 1'b0;
      c0 = cyc;
      switch_req_i = 1'b1;
      switch_dom_i = 2'd3;
      push_exp(1'b1, 2'd2, c0 + 65);
      tick();
      switch_req_i = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         if (k == 1 || k == 64) chk_eq($sformatf("timeout_stall_k%0d", k), stall_o, 1);
         tick();
      end
      chk_eq("timeout_stall_end", stall_o, 0);
      chk_eq("timeout_curdom", curdom_o, 2);

      // Flush in the same cycle the count reaches 0 (one still outstanding).
      c0 = cyc;
      switch_req_i = 1'b1;
      switch_dom_i = 2'd1;
      push_exp(1'b1, 2'd2, c0 + 4);
      tick();
      switch_req_i = 1'b0;
      tick();
      mem_retire_i = 1'b1;
      tick();
      mem_retire_i = 1'b0;
      flush_i      = 1'b1;
      tick();
      flush_i = 1'b0;
      chk_eq("flush_curdom", curdom_o, 2);
      chk_eq("flush_stall", stall_o, 0);
      tick();

      // Saturation: 10 issues, 8 retires, one extra retire at 0; flush during COMMIT ignored.
      mem_issue_i = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      mem_issue_i  = 1'b0;
      mem_retire_i = 1'b1;
      for (int k = 0; k < 9; k++) tick();
      mem_retire_i = 1'b0;
      c0 = cyc;
      switch_req_i = 1'b1;
      switch_dom_i = 2'd3;
      push_exp(1'b0, 2'd3, c0 + 3);
      tick();
      switch_req_i = 1'b0;
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk_eq("sat_curdom", curdom_o, 3);
      tick();

      // Reset mid-DRAIN with 3 outstanding.
      mem_issue_i = 1'b1;
      tick(); tick(); tick();
      mem_issue_i  = 1'b0;
      switch_req_i = 1'b1;
      switch_dom_i = 2'd1;
      tick();
      switch_req_i = 1'b0;
      tick();
      chk_eq("midrst_stall_before", stall_o, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk_eq("midrst_curdom", curdom_o, 0);
      chk_eq("midrst_stall", stall_o, 0);
      chk_eq("midrst_gnt", switch_gnt_o, 1);
      tick();
      rst_ni = 1'b1;
      tick();
      c0 = cyc;
      switch_req_i = 1'b1;
      switch_dom_i = 2'd1;
      push_exp(1'b0, 2'd1, c0 + 3);
      tick();
      switch_req_i = 1'b0;
      tick(); tick();
      chk_eq("postrst_curdom", curdom_o, 1);
      tick(); tick();

      chk_eq("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmp_domain_ctrl.md
Name: dmp_domain_ctrl

Overview:
- Owns the current DMP protection domain and drives it into the PMP/DMP checker's `curdom_i` port.
- Domain-switch requests are accepted through a req/gnt handshake.
- Before a switch commits, the block stalls new memory issue and drains in-flight accesses, so no access is checked against a domain it was not issued under.
- Sits between the CSR/decode stage that raises switch requests and the PMP/DMP check in the LSU/fetch path.

Parameters:
- MAX_OUTSTANDING, 8: maximum in-flight memory accesses tracked. Counter width is $clog2(MAX_OUTSTANDING+1).
- DRAIN_TIMEOUT, 64: maximum cycles spent in DRAIN before the switch is aborted with an error.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- switch_req_i  input  1  domain-switch request.
- switch_dom_i  input  riscv::dmp_domain_t  target domain, sampled on handshake.
- priv_lvl_i  input  riscv::priv_lvl_t  privilege level of the requester.
- switch_gnt_o  output  1  request accepted. Combinational; high only in IDLE.
- switch_done_o  output  1  one-cycle pulse: switch completed or no-op.
- switch_err_o  output  1  one-cycle pulse: switch refused, timed out, or aborted.
- mem_issue_i  input  1  one memory access issued this cycle.
- mem_retire_i  input  1  one memory access completed this cycle.
- flush_i  input  1  pipeline flush.
- stall_o  output  1  blocks new memory issue while a switch is pending.
- curdom_o  output  riscv::dmp_domain_t  current domain, registered; feeds pmp `curdom_i`.

Behaviour:
- Reset values (asynchronous on rst_ni low, including mid-switch):
  - curdom_o = riscv::DOM0
  - state = IDLE
  - outstanding = 0
  - timeout counter = 0
  - stall_o, switch_done_o, switch_err_o = 0
  - Any latched target is discarded.
- Outstanding counter:
  - Increments on mem_issue_i, decrements on mem_retire_i; both in the same cycle leaves it unchanged.
  - Saturates at MAX_OUTSTANDING and holds at 0; no wrap-around.
  - Counts in every state, including while stall_o is high, because accesses already past the stall point still count.
- Handshake: the transfer occurs when switch_req_i && switch_gnt_o. switch_gnt_o = (state == IDLE).
- State IDLE:
  - On handshake with priv_lvl_i == PRIV_LVL_U: switch_err_o pulses next cycle; stay in IDLE; curdom_o unchanged.
  - Else, on handshake with switch_dom_i == curdom_o: switch_done_o pulses next cycle; stay in IDLE; no drain, no stall.
  - Else, on handshake: latch the target, clear the timeout counter, go to DRAIN.
- State DRAIN:
  - stall_o = 1; the timeout counter increments each cycle.
  - flush_i = 1: go to IDLE, switch_err_o pulses next cycle, curdom_o unchanged. flush_i has priority over every other DRAIN exit.
  - Else, outstanding == 0 (registered value): go to COMMIT.
  - Else, timeout counter == DRAIN_TIMEOUT-1: go to IDLE, switch_err_o pulses next cycle.
- State COMMIT:
  - stall_o = 1.
  - At the exit edge, curdom_o <= latched target; go to IDLE.
  - switch_done_o is high in the first IDLE cycle, i.e. the same cycle curdom_o first shows the new value.
  - flush_i is ignored in COMMIT; the commit always completes.
- Minimum latency with nothing outstanding: handshake in cycle N → DRAIN in N+1 → COMMIT in N+2 → new curdom_o plus done in N+3.
- switch_done_o and switch_err_o:
  - Registered, single-cycle, never both high.
  - A new request may be granted in the same cycle as a done/err pulse.
- stall_o is registered-state-derived, with no combinational path from switch_req_i.

Test Plan:
- Reset mid-DRAIN: assert rst_ni=0 while in DRAIN with outstanding=3 → curdom_o=DOM0, stall_o=0, gnt=1, counter 0 after release.
- Clean switch, empty pipeline: curdom=DOM0, priv=M, req DOM1 at cycle 0 → stall_o high cycles 1–2; cycle 3 curdom_o=DOM1 with done=1 for exactly one cycle.
- Drain wait:
  - Setup: 3 issues then req DOM2.
  - Stimulus: retire one per cycle starting 5 cycles later, plus an issue and a retire together in one cycle.
  - Required: COMMIT entered only the cycle after the count reaches 0; curdom_o=DOM2; no err.
- Refusals and no-op:
  - Req from PRIV_LVL_U → err pulse, curdom unchanged, no stall.
  - Req with target == curdom → done pulse one cycle later, stall_o never asserted.
- Timeout and flush:
  - Timeout: DRAIN_TIMEOUT=64, outstanding held at 1 → err exactly 64 cycles after entering DRAIN, curdom unchanged.
  - Flush in the same cycle outstanding hits 0 → err, no commit.
- Counter saturation: 10 issues with MAX_OUTSTANDING=8 then 8 retires → count 0; a subsequent switch commits normally. An extra retire at 0 leaves the count at 0.
